// File: rtl/vga_pkg.sv
// Purpose : shared 640x480@60 raster timing defaults and the pixel coordinate type.
// Latency : n/a (package only).
// Backpressure: n/a; every pixel stage imports coord_t from here.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_delay_line.sv
// Purpose : DEPTH-stage async-reset flop chain.
//           Ports: clk_i/rst_ni clock and reset, d_i input word, q_o output word.
// Latency : DEPTH cycles from d_i to q_o.
// Backpressure: none; it shifts every cycle. Reset loads RESET_VAL into every stage.
module vga_delay_line #(
    parameter int                 WIDTH     = 2,
    parameter int                 DEPTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : raster timing generator. Outputs DrawX/DrawY counters, blank (1 = visible),
//           line_start/frame_start pulses, and active-low hs/vs to the DAC.
// Latency : DrawX/DrawY/blank/pulses have zero latency from the counters. hs/vs lag by SYNC_DLY (1..4)
//           cycles, which lines them up with the downstream colour path that registers one cycle late.
// Backpressure: none; free-running from the first edge after reset_n rises.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP,
    parameter int SYNC_DLY  = 1
) (
    input  logic   vga_clk,
    input  logic   reset_n,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   blank,
    output logic   hs,
    output logic   vs,
    output logic   line_start,
    output logic   frame_start
);

    localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t     hc_q, hc_d;
    coord_t     vc_q, vc_d;
    logic       running_q;
    logic       hs_raw, vs_raw;
    logic [1:0] sync_q;

    // Counters hold at 0,0 until running is set, so the first edge after
    // reset release presents pixel (0,0) with running=1 and the first frame is full length.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (running_q) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + coord_t'(1);
            end else begin
                hc_d = hc_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q      <= '0;
            vc_q      <= '0;
            running_q <= 1'b0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            running_q <= 1'b1;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = running_q && (hc_q < H_VIS_C) && (vc_q < V_VIS_C);
    assign line_start  = running_q && (hc_q == '0) && (vc_q < V_VIS_C);
    assign frame_start = running_q && (hc_q == '0) && (vc_q == '0);

    // vs_raw depends only on the line number, so it spans whole lines including hblank.
    assign hs_raw = !((hc_q >= HS_START) && (hc_q < HS_END));
    assign vs_raw = !((vc_q >= VS_START) && (vc_q < VS_END));

    // Reset forces every stage high, so a sync pulse in flight is dropped, not finished.
    vga_delay_line #(
        .WIDTH    (2),
        .DEPTH    (SYNC_DLY),
        .RESET_VAL(2'b11)
    ) u_sync_dly (
        .clk_i (vga_clk),
        .rst_ni(reset_n),
        .d_i   ({hs_raw, vs_raw}),
        .q_o   (sync_q)
    );

    assign hs = sync_q[1];
    assign vs = sync_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose : self-checking bench for vga_timing_gen. It runs a full-size 640x480 instance with SYNC_DLY=1,
//           plus two reduced-raster instances (SYNC_DLY=1 and 3) so that whole frames fit in a short run.
// Latency : expected hs/vs pass through a scoreboard queue that is SYNC_DLY entries deep per instance.
module tb_vga_timing_gen;

    localparam int NI = 3;
    localparam int HV  [NI] = '{640, 8, 8};
    localparam int HF  [NI] = '{16,  2, 2};
    localparam int HSW [NI] = '{96,  3, 3};
    localparam int HB  [NI] = '{48,  3, 3};
    localparam int VV  [NI] = '{480, 6, 6};
    localparam int VF  [NI] = '{10,  1, 1};
    localparam int VSW [NI] = '{2,   2, 2};
    localparam int VB  [NI] = '{33,  2, 2};
    localparam int DLY [NI] = '{1,   1, 3};

    logic       vga_clk;
    logic       reset_n;
    logic [9:0] dx [NI];
    logic [9:0] dy [NI];
    logic       bl [NI];
    logic       hs [NI];
    logic       vs [NI];
    logic       ls [NI];
    logic       fs [NI];

    int n_checks = 0;
    int n_fail   = 0;

    vga_timing_gen u_full (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[0]), .DrawY(dy[0]), .blank(bl[0]),
        .hs(hs[0]), .vs(vs[0]), .line_start(ls[0]), .frame_start(fs[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DLY(1)
    ) u_small_d1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[1]), .DrawY(dy[1]), .blank(bl[1]),
        .hs(hs[1]), .vs(vs[1]), .line_start(ls[1]), .frame_start(fs[1])
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DLY(3)
    ) u_small_d3 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[2]), .DrawY(dy[2]), .blank(bl[2]),
        .hs(hs[2]), .vs(vs[2]), .line_start(ls[2]), .frame_start(fs[2])
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference raster model; sync expectations go into sq[i] and are popped SYNC_DLY edges later.
    int         m_hc  [NI];
    int         m_vc  [NI];
    bit         m_run [NI];
    logic [1:0] sq    [NI][$];

    always @(posedge vga_clk or negedge reset_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!reset_n) begin
                m_hc[i]  = 0;
                m_vc[i]  = 0;
                m_run[i] = 1'b0;
                sq[i].delete();
                for (int k = 0; k < DLY[i]; k++) sq[i].push_back(2'b11);
            end else begin
                logic hr, vr;
                int   ht, vt;
                ht = HV[i] + HF[i] + HSW[i] + HB[i];
                vt = VV[i] + VF[i] + VSW[i] + VB[i];
                hr = !((m_hc[i] >= HV[i] + HF[i]) && (m_hc[i] < HV[i] + HF[i] + HSW[i]));
                vr = !((m_vc[i] >= VV[i] + VF[i]) && (m_vc[i] < VV[i] + VF[i] + VSW[i]));
                sq[i].push_back({hr, vr});
                void'(sq[i].pop_front());
                if (m_run[i]) begin
                    if (m_hc[i] == ht - 1) begin
                        m_hc[i] = 0;
                        m_vc[i] = (m_vc[i] == vt - 1) ? 0 : m_vc[i] + 1;
                    end else begin
                        m_hc[i] = m_hc[i] + 1;
                    end
                end
                m_run[i] = 1'b1;
            end
        end
    end

    // Per-cycle comparison plus pulse-width / period measurements.
    int   cyc = 0;
    logic p_hs [NI] = '{1'b1, 1'b1, 1'b1};
    logic p_vs [NI] = '{1'b1, 1'b1, 1'b1};
    int   hs_st [NI], vs_st [NI], fs_last [NI], ls_cnt [NI], bl_cnt [NI], hs_fall [NI];

    always @(negedge vga_clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            int ht, vt;
            ht = HV[i] + HF[i] + HSW[i] + HB[i];
            vt = VV[i] + VF[i] + VSW[i] + VB[i];
            chk($sformatf("DrawX[%0d]", i), 32'(dx[i]), m_hc[i]);
            chk($sformatf("DrawY[%0d]", i), 32'(dy[i]), m_vc[i]);
            chk($sformatf("blank[%0d]", i), 32'(bl[i]),
                32'(m_run[i] && m_hc[i] < HV[i] && m_vc[i] < VV[i]));
            chk($sformatf("line_start[%0d]", i), 32'(ls[i]),
                32'(m_run[i] && m_hc[i] == 0 && m_vc[i] < VV[i]));
            chk($sformatf("frame_start[%0d]", i), 32'(fs[i]),
                32'(m_run[i] && m_hc[i] == 0 && m_vc[i] == 0));
            if (sq[i].size() > 0) begin
                chk($sformatf("hs[%0d]", i), 32'(hs[i]), 32'(sq[i][0][1]));
                chk($sformatf("vs[%0d]", i), 32'(vs[i]), 32'(sq[i][0][0]));
            end
            if (!reset_n) begin
                hs_st[i]   = -1;
                vs_st[i]   = -1;
                fs_last[i] = -1;
                hs_fall[i] = -1;
            end else begin
                if (fs[i]) begin
                    if (fs_last[i] >= 0) begin
                        chk($sformatf("frame_period[%0d]", i), cyc - fs_last[i], ht * vt);
                        chk($sformatf("line_starts[%0d]", i), ls_cnt[i], VV[i]);
                        chk($sformatf("blank_cycles[%0d]", i), bl_cnt[i], HV[i] * VV[i]);
                    end
                    fs_last[i] = cyc;
                    ls_cnt[i]  = 0;
                    bl_cnt[i]  = 0;
                end
                ls_cnt[i] += int'(ls[i]);
                bl_cnt[i] += int'(bl[i]);
                if (p_hs[i] && !hs[i]) begin
                    hs_st[i] = cyc;
                    chk($sformatf("hs_fall_x[%0d]", i), 32'(dx[i]), HV[i] + HF[i] + DLY[i]);
                    if (i == 2 && hs_fall[1] >= 0)
                        chk("hs_dly3_vs_dly1", cyc - hs_fall[1], 2);
                    hs_fall[i] = cyc;
                end
                if (!p_hs[i] && hs[i] && hs_st[i] >= 0)
                    chk($sformatf("hs_width[%0d]", i), cyc - hs_st[i], HSW[i]);
                if (p_vs[i] && !vs[i]) begin
                    vs_st[i] = cyc;
                    chk($sformatf("vs_fall_x[%0d]", i), 32'(dx[i]), DLY[i]);
                    chk($sformatf("vs_fall_y[%0d]", i), 32'(dy[i]), VV[i] + VF[i]);
                end
                if (!p_vs[i] && vs[i] && vs_st[i] >= 0)
                    chk($sformatf("vs_width[%0d]", i), cyc - vs_st[i], VSW[i] * ht);
            end
            p_hs[i] = hs[i];
            p_vs[i] = vs[i];
        end
    end

    // Release reset and check the first visible line of the full-size raster directly.
    task automatic release_and_check(input string tag);
        @(negedge vga_clk);
        #2 reset_n = 1'b1;
        @(negedge vga_clk);
        chk({tag, "_fs_first"},    32'(fs[0]), 1);
        chk({tag, "_blank_first"}, 32'(bl[0]), 1);
        chk({tag, "_x_first"},     32'(dx[0]), 0);
        chk({tag, "_y_first"},     32'(dy[0]), 0);
        repeat (639) @(negedge vga_clk);
        chk({tag, "_x_639"},     32'(dx[0]), 639);
        chk({tag, "_blank_639"}, 32'(bl[0]), 1);
        @(negedge vga_clk);
        chk({tag, "_x_640"},     32'(dx[0]), 640);
        chk({tag, "_blank_640"}, 32'(bl[0]), 0);
        repeat (2600) @(negedge vga_clk);
        chk({tag, "_y_after_run"}, 32'(dy[0]), 4);
    endtask

    initial begin
        bit found;
        reset_n = 1'b0;
        repeat (10) @(posedge vga_clk);
        release_and_check("run1");

        // Park the small rasters inside both sync pulses, then reset.
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge vga_clk);
            if (dx[1] == 10'd12 && dy[1] == 10'd8) found = 1'b1;
        end
        chk("find_midsync", 32'(found), 1);
        chk("pre_rst_hs", 32'(hs[1]), 0);
        chk("pre_rst_vs", 32'(vs[1]), 0);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_hs[%0d]", i), 32'(hs[i]), 1);
            chk($sformatf("rst_vs[%0d]", i), 32'(vs[i]), 1);
            chk($sformatf("rst_x[%0d]", i),  32'(dx[i]), 0);
            chk($sformatf("rst_y[%0d]", i),  32'(dy[i]), 0);
            chk($sformatf("rst_bl[%0d]", i), 32'(bl[i]), 0);
        end
        repeat (5) @(posedge vga_clk);
        release_and_check("run2");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
